hdmi_video_sched: RTL and testbench

Pixel-clock scheduler that sequences the HDMI output datapath. It generates 640x480@60 raster timing and pulls pixels from an upstream valid/ready pixel stream exactly when the raster needs them. It drives the 4-bit RGB, sync and blank inputs of svo_hdmi_out, and handles frame alignment, underflow and resynchronisation so the TMDS encoders always receive a legal raster.

---
 rtl/hdmi_video_pkg.sv | 25 ++
 rtl/hdmi_video_timing.sv | 57 +++++
 rtl/hdmi_video_sched.sv | 134 +++++++++++++
 tb/tb_hdmi_video_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_video_pkg.sv
// Shared 640x480@60 timing defaults and the scheduler state type for the HDMI video path.
package hdmi_video_pkg;

  localparam int VGA_BPC      = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HCNT_W  = $clog2(VGA_H_TOTAL);
  localparam int VGA_VCNT_W  = $clog2(VGA_V_TOTAL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/hdmi_video_timing.sv
// Free-running raster counters with active / sync / frame-origin decode.
// Carries no pixel flow so other video blocks can reuse it.
module hdmi_video_timing
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk_pixel,
  input  logic resetn,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic origin
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_AEND  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_AEND  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign active = (hcnt < H_AEND) && (vcnt < V_AEND);
  assign hsync  = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vsync  = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign origin = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/hdmi_video_sched.sv
// Pulls pixels from a valid/ready stream exactly when the raster needs them and
// drives registered colour / sync / blank to the HDMI output stage.
//   state | meaning
//   IDLE  | no pixel flow, raster free-runs with fill colour
//   SYNC  | dropping beats until an SOF beat is held for the next frame origin
//   RUN   | one beat consumed per active pixel
module hdmi_video_sched
  import hdmi_video_pkg::*;
#(
  parameter int BPC      = VGA_BPC,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter logic [3*BPC-1:0] FILL_RGB = '0
) (
  input  logic           clk_pixel,
  input  logic           resetn,
  input  logic           enable,
  input  logic           in_tvalid,
  output logic           in_tready,
  input  logic [3*BPC-1:0] in_tdata,
  input  logic           in_tuser,
  output logic [BPC-1:0] rout,
  output logic [BPC-1:0] gout,
  output logic [BPC-1:0] bout,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           hblnk_n,
  output logic           frame_start,
  output logic           err_underflow,
  output logic           err_sync,
  output logic           running
);

  logic active, hsync, vsync, origin;
  sched_state_t state_q, state_d;
  logic take, uf_d, se_d;
  logic [3*BPC-1:0] rgb_q;

  hdmi_video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .active    (active),
    .hsync     (hsync),
    .vsync     (vsync),
    .origin    (origin)
  );

  always_comb begin
    state_d   = state_q;
    in_tready = 1'b0;
    take      = 1'b0;
    uf_d      = 1'b0;
    se_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && origin) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (origin && !enable) begin
          state_d = ST_IDLE;
        end else if (in_tvalid && in_tuser) begin
          // SOF stays at the head until the raster reaches its origin
          if (origin) begin
            in_tready = 1'b1;
            take      = 1'b1;
            state_d   = ST_RUN;
          end
        end else begin
          in_tready = 1'b1;
        end
      end
      ST_RUN: begin
        if (origin && !enable) begin
          state_d = ST_IDLE;
        end else if (active) begin
          if (!in_tvalid) begin
            uf_d = 1'b1;
          end else if (in_tuser != origin) begin
            // misplaced or missing SOF: leave the beat for SYNC to judge
            se_d    = 1'b1;
            state_d = ST_SYNC;
          end else begin
            in_tready = 1'b1;
            take      = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      rgb_q         <= FILL_RGB;
      hsync_n       <= 1'b1;
      vsync_n       <= 1'b1;
      hblnk_n       <= 1'b1;
      frame_start   <= 1'b0;
      err_underflow <= 1'b0;
      err_sync      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rgb_q         <= take ? in_tdata : FILL_RGB;
      hsync_n       <= ~hsync;
      vsync_n       <= ~vsync;
      hblnk_n       <= ~active;
      frame_start   <= origin;
      err_underflow <= uf_d;
      err_sync      <= se_d;
    end
  end

  assign rout    = rgb_q[BPC-1:0];
  assign gout    = rgb_q[2*BPC-1:BPC];
  assign bout    = rgb_q[3*BPC-1:2*BPC];
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_hdmi_video_sched.sv
// Randomised-data bench for hdmi_video_sched on a shrunken raster, checked against
// a cycle model derived from raster position and the scheduler rules.
module tb_hdmi_video_sched;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [11:0] FILL = 12'h5A3;
  // {tready, rgb, hsync_n, vsync_n, hblnk_n, frame_start, err_uf, err_sync, running}
  localparam logic [19:0] RST_V = {1'b0, FILL, 7'b1110000};
  localparam int M_IDLE = 0, M_SYNC = 1, M_RUN = 2;

  logic clk_pixel = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic in_tvalid = 1'b0;
  logic in_tready;
  logic [11:0] in_tdata = '0;
  logic in_tuser = 1'b0;
  logic [3:0] rout, gout, bout;
  logic hsync_n, vsync_n, hblnk_n, frame_start, err_underflow, err_sync, running;

  int n_cmp = 0;
  int n_fail = 0;
  logic [12:0] src_q[$];
  int pos, mst;
  logic [19:0] obs_v, exp_v;
  logic acc, obs_tready;

  hdmi_video_sched #(
    .BPC(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FILL_RGB(FILL)
  ) dut (
    .clk_pixel(clk_pixel), .resetn(resetn), .enable(enable),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tuser(in_tuser),
    .rout(rout), .gout(gout), .bout(bout),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .hblnk_n(hblnk_n),
    .frame_start(frame_start), .err_underflow(err_underflow), .err_sync(err_sync),
    .running(running)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic push_frame();
    for (int i = 0; i < HA * VA; i++)
      src_q.push_back({(i == 0), 12'($urandom)});
  endtask

  task automatic assert_reset();
    #2 resetn = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk_pixel);
    src_q.delete();
    pos = 0;
    mst = M_IDLE;
    resetn = 1'b1;
  endtask

  // One pixel clock: drive source head, predict from raster position, sample after the edge.
  task automatic tick(input logic en, input logic vld_allow);
    logic [12:0] head;
    int h, v, nxt;
    logic act, org, sof, m_tr, m_take, m_uf, m_se, hs_on, vs_on;
    head = (src_q.size() > 0) ? src_q[0] : 13'h0;
    enable = en;
    in_tvalid = vld_allow && (src_q.size() > 0);
    in_tdata = head[11:0];
    in_tuser = head[12];
    #1;
    obs_tready = in_tready;
    h = pos % HT;
    v = pos / HT;
    act = (h < HA) && (v < VA);
    org = (pos == 0);
    sof = in_tvalid && in_tuser;
    m_tr = 0; m_take = 0; m_uf = 0; m_se = 0; nxt = mst;
    if (mst == M_IDLE) begin
      if (org && en) nxt = M_SYNC;
    end else if (org && !en) begin
      nxt = M_IDLE;
    end else if (mst == M_SYNC) begin
      m_tr = org || !sof;
      if (org && sof) begin m_take = 1; nxt = M_RUN; end
    end else if (act) begin
      if (!in_tvalid) m_uf = 1;
      else if (in_tuser != org) begin m_se = 1; nxt = M_SYNC; end
      else begin m_tr = 1; m_take = 1; end
    end
    hs_on = (h >= HA + HF) && (h < HA + HF + HS);
    vs_on = (v >= VA + VF) && (v < VA + VF + VS);
    exp_v = {m_tr, (m_take ? head[11:0] : FILL), !hs_on, !vs_on, !act, org, m_uf, m_se, (nxt == M_RUN)};
    @(posedge clk_pixel);
    #1;
    acc = obs_tready && in_tvalid;
    if (acc) head = src_q.pop_front();
    obs_v = {obs_tready, bout, gout, rout, hsync_n, vsync_n, hblnk_n, frame_start,
             err_underflow, err_sync, running};
    pos = (pos + 1) % FT;
    mst = nxt;
    @(negedge clk_pixel);
  endtask

  task automatic test_reset();
    logic [19:0] v;
    enable = 1'b1; in_tvalid = 1'b1; in_tuser = 1'b1;
    assert_reset();
    v = {in_tready, bout, gout, rout, hsync_n, vsync_n, hblnk_n, frame_start,
         err_underflow, err_sync, running};
    n_cmp++;
    if (v !== RST_V) begin n_fail++; $display("FAIL reset_values got=%h exp=%h", v, RST_V); end
    release_reset();
    push_frame();
    for (int c = 0; c < 2 * HT; c++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL idle_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_stream_basic();
    int acc_f1 = 0, hs_low = 0, vs_low = 0, errs = 0;
    logic [11:0] first;
    assert_reset();
    release_reset();
    for (int f = 0; f < 4; f++) push_frame();
    first = src_q[0][11:0];
    for (int c = 0; c < 3 * FT; c++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL basic_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c >= FT && c < 2 * FT) begin
        acc_f1 += int'(acc);
        hs_low += int'(!obs_v[6]);
        vs_low += int'(!obs_v[5]);
      end
      errs += int'(obs_v[2]) + int'(obs_v[1]);
      if (c == FT) begin
        n_cmp++;
        if (obs_v[18:7] !== first || obs_v[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_first_pixel got=%h run=%b exp=%h run=1", obs_v[18:7], obs_v[0], first);
        end
      end
    end
    n_cmp++;
    if (acc_f1 !== HA * VA) begin n_fail++; $display("FAIL basic_beats got=%0d exp=%0d", acc_f1, HA * VA); end
    n_cmp++;
    if (hs_low !== HS * VT) begin n_fail++; $display("FAIL basic_hsync_low got=%0d exp=%0d", hs_low, HS * VT); end
    n_cmp++;
    if (vs_low !== VS * HT) begin n_fail++; $display("FAIL basic_vsync_low got=%0d exp=%0d", vs_low, VS * HT); end
    n_cmp++;
    if (errs !== 0) begin n_fail++; $display("FAIL basic_errors got=%0d exp=0", errs); end
  endtask

  task automatic test_sof_search();
    int dropped = 0;
    logic [11:0] sixth;
    assert_reset();
    release_reset();
    for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 12'($urandom)});
    push_frame();
    push_frame();
    sixth = src_q[5][11:0];
    for (int c = 0; c < 2 * FT; c++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL search_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c < FT) dropped += int'(acc);
      if (c == FT) begin
        n_cmp++;
        if (obs_v[18:7] !== sixth) begin
          n_fail++;
          $display("FAIL search_origin_pixel got=%h exp=%h", obs_v[18:7], sixth);
        end
      end
    end
    n_cmp++;
    if (dropped !== 5) begin n_fail++; $display("FAIL search_dropped got=%0d exp=5", dropped); end
  endtask

  task automatic test_underflow();
    int uf = 0, se = 0, acc_f3 = 0;
    int w0;
    w0 = FT + 2 * HT + 5;
    assert_reset();
    release_reset();
    for (int f = 0; f < 3; f++) push_frame();
    for (int c = 0; c < 4 * FT; c++) begin
      tick(1'b1, !(c >= w0 && c < w0 + 3));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL uflow_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      uf += int'(obs_v[2]);
      se += int'(obs_v[1]);
      if (c >= 3 * FT) acc_f3 += int'(acc);
      if (c >= w0 && c < w0 + 3) begin
        n_cmp++;
        if (obs_v[18:7] !== FILL || obs_v[2] !== 1'b1) begin
          n_fail++;
          $display("FAIL uflow_fill c=%0d got=%h uf=%b exp=%h uf=1", c, obs_v[18:7], obs_v[2], FILL);
        end
      end
      if (c == 2 * FT) begin
        n_cmp++;
        if (obs_v[1] !== 1'b1 || obs_v[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL uflow_resync got se=%b run=%b exp se=1 run=0", obs_v[1], obs_v[0]);
        end
      end
    end
    n_cmp++;
    if (uf !== 3) begin n_fail++; $display("FAIL uflow_count got=%0d exp=3", uf); end
    n_cmp++;
    if (se !== 1) begin n_fail++; $display("FAIL uflow_sync_count got=%0d exp=1", se); end
    n_cmp++;
    if (acc_f3 !== HA * VA || running !== 1'b1) begin
      n_fail++;
      $display("FAIL uflow_realign got beats=%0d run=%b exp beats=%0d run=1", acc_f3, running, HA * VA);
    end
  endtask

  task automatic test_sof_inject();
    int se01 = 0;
    int ci;
    logic [11:0] inj;
    ci = FT + HT + 10;
    assert_reset();
    release_reset();
    for (int f = 0; f < 3; f++) push_frame();
    src_q[26] = {1'b1, src_q[26][11:0]};
    inj = src_q[26][11:0];
    for (int c = 0; c < 3 * FT; c++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL inject_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c < 2 * FT) se01 += int'(obs_v[1]);
      if (c == ci) begin
        n_cmp++;
        if (obs_v[1] !== 1'b1 || acc !== 1'b0) begin
          n_fail++;
          $display("FAIL inject_err got se=%b acc=%b exp se=1 acc=0", obs_v[1], acc);
        end
      end
      if (c == 2 * FT) begin
        n_cmp++;
        if (obs_v[18:7] !== inj || obs_v[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL inject_resume got=%h run=%b exp=%h run=1", obs_v[18:7], obs_v[0], inj);
        end
      end
    end
    n_cmp++;
    if (se01 !== 1) begin n_fail++; $display("FAIL inject_count got=%0d exp=1", se01); end
  endtask

  task automatic test_disable();
    int acc_f1 = 0, acc_f2 = 0, nonfill = 0, hs_low = 0;
    assert_reset();
    release_reset();
    for (int f = 0; f < 4; f++) push_frame();
    for (int c = 0; c < 3 * FT; c++) begin
      tick(c < FT + 100, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL disable_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c >= FT && c < 2 * FT) acc_f1 += int'(acc);
      if (c >= 2 * FT) begin
        acc_f2 += int'(obs_tready);
        nonfill += int'(obs_v[18:7] !== FILL);
        hs_low += int'(!obs_v[6]);
      end
      if (c == 2 * FT) begin
        n_cmp++;
        if (obs_v[0] !== 1'b0 || obs_v[3] !== 1'b1) begin
          n_fail++;
          $display("FAIL disable_idle got run=%b fs=%b exp run=0 fs=1", obs_v[0], obs_v[3]);
        end
      end
    end
    n_cmp++;
    if (acc_f1 !== HA * VA) begin n_fail++; $display("FAIL disable_finish got=%0d exp=%0d", acc_f1, HA * VA); end
    n_cmp++;
    if (acc_f2 !== 0 || nonfill !== 0) begin
      n_fail++;
      $display("FAIL disable_quiet got ready=%0d nonfill=%0d exp 0 0", acc_f2, nonfill);
    end
    n_cmp++;
    if (hs_low !== HS * VT) begin n_fail++; $display("FAIL disable_timing got=%0d exp=%0d", hs_low, HS * VT); end
  endtask

  task automatic test_reset_async();
    logic [19:0] v;
    assert_reset();
    release_reset();
    for (int f = 0; f < 3; f++) push_frame();
    for (int c = 0; c < FT + 3 * HT + 7; c++) tick(1'b1, 1'b1);
    n_cmp++;
    if (running !== 1'b1 || hblnk_n !== 1'b0) begin
      n_fail++;
      $display("FAIL async_pre got run=%b blnk=%b exp run=1 blnk=0", running, hblnk_n);
    end
    assert_reset();
    v = {in_tready, bout, gout, rout, hsync_n, vsync_n, hblnk_n, frame_start,
         err_underflow, err_sync, running};
    n_cmp++;
    if (v !== RST_V) begin n_fail++; $display("FAIL async_reset_values got=%h exp=%h", v, RST_V); end
    release_reset();
    tick(1'b0, 1'b1);
    n_cmp++;
    if (obs_v !== exp_v || obs_v[3] !== 1'b1 || obs_v[6] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_restart got=%h exp=%h (fs=1 hs_n=1)", obs_v, exp_v);
    end
  endtask

  initial begin
    pos = 0;
    mst = M_IDLE;
    @(negedge clk_pixel);
    test_reset();
    test_stream_basic();
    test_sof_search();
    test_underflow();
    test_sof_inject();
    test_disable();
    test_reset_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
